// File: rtl/m2vmc_resadd.sv
// Motion-compensation residual adder: walks the 32 pair addresses of the IDCT read
// page, adds residuals to prediction pixels, clips to 0..255 and streams the pairs.
`timescale 1ns/1ps
module m2vmc_resadd #(
    parameter int OFIFO_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              softreset,
    input  logic              blk_start,
    input  logic              blk_coded,
    input  logic              blk_intra,
    output logic              ready_mc,
    output logic              pixel_coded,
    output logic [4:0]        pixel_addr,
    input  logic signed [8:0] pixel_data0,
    input  logic signed [8:0] pixel_data1,
    input  logic              pred_valid,
    output logic              pred_ready,
    input  logic [15:0]       pred_data,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [15:0]       rec_data,
    output logic              rec_last,
    output logic              blk_done
);
    localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int CW = $clog2(OFIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(OFIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic [7:0] clip_pix(input logic [7:0] pred,
                                            input logic signed [8:0] res);
        logic signed [9:0] sum;
        sum = $signed({2'b00, pred}) + $signed({res[8], res});
        if (sum < 10'sd0)
            clip_pix = 8'd0;
        else if (sum > 10'sd255)
            clip_pix = 8'd255;
        else
            clip_pix = sum[7:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(OFIFO_DEPTH - 1))
            ptr_inc = '0;
        else
            ptr_inc = ptr + 1'b1;
    endfunction

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            coded_q, coded_d;
    logic            intra_q, intra_d;
    logic            sb_valid_q, sb_valid_d;
    logic [15:0]     sb_pred_q, sb_pred_d;
    logic            sb_last_q, sb_last_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fcnt_q, fcnt_d;
    logic            blk_done_q, blk_done_d;
    logic [16:0]     fifo_mem [OFIFO_DEPTH];

    logic [CW:0]       credit;
    logic              issue;
    logic              push;
    logic              pop;
    logic [16:0]       head;
    logic [16:0]       push_entry;
    logic signed [8:0] res0;
    logic signed [8:0] res1;

    // Issue stage: stage B is charged against the FIFO credit so the FIFO cannot overflow
    always_comb begin
        credit     = {1'b0, fcnt_q} + {{CW{1'b0}}, sb_valid_q};
        issue      = (state_q == S_RUN) && !cnt_q[5] && (intra_q || pred_valid)
                     && (credit < DEPTH_C) && !softreset;
        rec_valid  = (fcnt_q != '0);
        pop        = rec_valid && rec_ready;
        push       = sb_valid_q;
        head       = fifo_mem[rd_ptr_q];
        res0       = coded_q ? pixel_data0 : 9'sd0;
        res1       = coded_q ? pixel_data1 : 9'sd0;
        push_entry = {sb_last_q, clip_pix(sb_pred_q[15:8], res1),
                      clip_pix(sb_pred_q[7:0], res0)};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        coded_d    = coded_q;
        intra_d    = intra_q;
        sb_valid_d = issue;
        sb_pred_d  = sb_pred_q;
        sb_last_d  = sb_last_q;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fcnt_d     = fcnt_q;
        blk_done_d = 1'b0;

        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase

        if (issue) begin
            cnt_d     = cnt_q + 6'd1;
            sb_pred_d = intra_q ? 16'h0000 : pred_data;
            sb_last_d = (cnt_q[4:0] == 5'd31);
        end

        case (state_q)
            S_IDLE: begin
                if (blk_start) begin
                    coded_d = blk_coded;
                    intra_d = blk_intra;
                    cnt_d   = 6'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q[5])
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // Pair 31 is always the final entry, so its acceptance empties the pipe
                if (pop && head[16] && (fcnt_q == CW'(1)) && !sb_valid_q) begin
                    state_d    = S_IDLE;
                    blk_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (softreset) begin
            state_d    = S_IDLE;
            cnt_d      = 6'd0;
            coded_d    = 1'b0;
            intra_d    = 1'b0;
            sb_valid_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fcnt_d     = '0;
            blk_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            coded_q    <= 1'b0;
            intra_q    <= 1'b0;
            sb_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            coded_q    <= coded_d;
            intra_q    <= intra_d;
            sb_valid_q <= sb_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            blk_done_q <= blk_done_d;
        end
    end

    // Stage B / FIFO payload: data-only registers, qualified by the control valids
    always_ff @(posedge clk) begin
        sb_pred_q <= sb_pred_d;
        sb_last_q <= sb_last_d;
        if (push)
            fifo_mem[wr_ptr_q] <= push_entry;
    end

    assign ready_mc    = (state_q == S_IDLE);
    assign pixel_coded = coded_q;
    assign pixel_addr  = cnt_q[4:0];
    assign pred_ready  = issue && !intra_q;
    assign rec_data    = rec_valid ? head[15:0] : 16'h0000;
    assign rec_last    = rec_valid && head[16];
    assign blk_done    = blk_done_q;

endmodule

// File: tb/tb_m2vmc_resadd.sv
// Randomized scoreboard bench for m2vmc_resadd with a behavioural IDCT page model.
`timescale 1ns/1ps
module tb_m2vmc_resadd;
    logic              clk = 1'b0;
    logic              reset_n;
    logic              softreset;
    logic              blk_start;
    logic              blk_coded;
    logic              blk_intra;
    logic              ready_mc;
    logic              pixel_coded;
    logic [4:0]        pixel_addr;
    logic signed [8:0] pixel_data0;
    logic signed [8:0] pixel_data1;
    logic              pred_valid;
    logic              pred_ready;
    logic [15:0]       pred_data;
    logic              rec_valid;
    logic              rec_ready;
    logic [15:0]       rec_data;
    logic              rec_last;
    logic              blk_done;

    m2vmc_resadd #(.OFIFO_DEPTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .softreset(softreset),
        .blk_start(blk_start), .blk_coded(blk_coded), .blk_intra(blk_intra),
        .ready_mc(ready_mc), .pixel_coded(pixel_coded), .pixel_addr(pixel_addr),
        .pixel_data0(pixel_data0), .pixel_data1(pixel_data1),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .rec_last(rec_last), .blk_done(blk_done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [16:0] exp_q[$];
    int          preds[32];
    int          r0[32];
    int          r1[32];
    int          pidx = 0;
    int          pv_mode = 0;
    int          rr_mode = 0;
    bit          cur_intra = 0;
    int          intra_bad = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          acc_cnt = 0;
    bit          done_due = 0;
    bit          prev_stall = 0;
    logic [16:0] prev_out;
    logic [16:0] mon_e;
    int          first_issue, last_issue, first_valid, last_valid, n_valid;

    always @(posedge clk) cyc <= cyc + 1;

    // IDCT read page: registered read, garbage when the block carries no residual
    always @(posedge clk) begin
        if (pixel_coded) begin
            pixel_data0 <= 9'(r0[pixel_addr]);
            pixel_data1 <= 9'(r1[pixel_addr]);
        end else begin
            pixel_data0 <= 9'($urandom);
            pixel_data1 <= 9'($urandom);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic logic [16:0] model(input int p, input int a, input int b,
                                          input bit c, input bit in, input bit last);
        int pe, po, ra, rb;
        pe = in ? 0 : (p & 255);
        po = in ? 0 : ((p >> 8) & 255);
        ra = c ? a : 0;
        rb = c ? b : 0;
        return {last, 8'(clamp(po + rb)), 8'(clamp(pe + ra))};
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (done_due) begin
                check("blk_done_pulse", int'(blk_done), 1);
                if (blk_done) done_cnt++;
                done_due = 0;
            end else if (blk_done) begin
                check("blk_done_spurious", int'(blk_done), 0);
            end
            if (pred_ready) begin
                check("pixel_addr", int'(pixel_addr), pidx);
                if (cur_intra) intra_bad++;
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
            end
            if (prev_stall) begin
                check("stall_valid", int'(rec_valid), 1);
                check("stall_data", int'({rec_last, rec_data}), int'(prev_out));
            end
            if (rec_valid) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                n_valid++;
            end
            if (rec_valid && rec_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_pair: got %0h with none expected", {rec_last, rec_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rec_pair", int'({rec_last, rec_data}), int'(mon_e));
                    if (mon_e[16]) done_due = 1;
                end
            end
            prev_stall = rec_valid && !rec_ready && !softreset;
            prev_out   = {rec_last, rec_data};
        end
    end

    task automatic drive_modes();
        case (pv_mode)
            0:       pred_valid = 1'b1;
            1:       pred_valid = 1'($urandom_range(0, 1));
            default: pred_valid = 1'b0;
        endcase
        case (rr_mode)
            0:       rec_ready = 1'b1;
            1:       rec_ready = ~rec_ready;
            default: rec_ready = 1'($urandom_range(0, 1));
        endcase
        pred_data = (pidx < 32) ? 16'(preds[pidx]) : 16'($urandom);
    endtask

    task automatic cycle();
        bit take;
        @(negedge clk);
        take = pred_valid && pred_ready;
        @(posedge clk);
        #1;
        if (take) pidx++;
        blk_start = 1'b0;
        softreset = 1'b0;
        blk_coded = 1'($urandom_range(0, 1));
        blk_intra = 1'($urandom_range(0, 1));
        drive_modes();
    endtask

    task automatic prep_block(input bit c, input bit in, input int vec);
        for (int k = 0; k < 32; k++) begin
            preds[k] = int'($urandom_range(0, 65535));
            r0[k] = int'($urandom_range(0, 511)) - 256;
            r1[k] = int'($urandom_range(0, 511)) - 256;
            if (vec == 1) preds[k] = ((2 * k + 2) << 8) | (2 * k + 1);
            if (vec == 3) begin
                r0[k] = 100;
                r1[k] = -3;
            end
        end
        if (vec == 2) begin
            preds[0] = 'h10F0; r0[0] = 20;   r1[0] = -20;
            preds[1] = 'h0005; r0[1] = -256; r1[1] = 255;
            preds[2] = 'h8080; r0[2] = 0;    r1[2] = 0;
        end
        for (int k = 0; k < 32; k++)
            exp_q.push_back(model(preds[k], r0[k], r1[k], c, in, k == 31));
        pidx = 0;
        cur_intra = in;
        intra_bad = 0;
        first_issue = -1;
        first_valid = -1;
        last_issue = 0;
        last_valid = 0;
        n_valid = 0;
        done_base = done_cnt;
    endtask

    task automatic start_block(input bit c, input bit in, input int pvm, input int rrm);
        pv_mode = pvm;
        rr_mode = rrm;
        for (int i = 0; i < 50 && !ready_mc; i++) cycle();
        blk_start = 1'b1;
        blk_coded = c;
        blk_intra = in;
        drive_modes();
        cycle();
        check("pixel_coded", int'(pixel_coded), int'(c));
        check("busy_after_start", int'(ready_mc), 0);
    endtask

    task automatic finish_block(input bit in);
        for (int i = 0; i < 400 && done_cnt == done_base; i++) cycle();
        check("block_completed", done_cnt - done_base, 1);
        check("queue_drained", exp_q.size(), 0);
        if (in) check("intra_pred_ready", intra_bad, 0);
    endtask

    task automatic run_block(input bit c, input bit in, input int pvm, input int rrm,
                             input int vec);
        prep_block(c, in, vec);
        start_block(c, in, pvm, rrm);
        finish_block(in);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        bit c, in;
        reset_n = 1'b0; softreset = 1'b0; blk_start = 1'b0;
        blk_coded = 1'b0; blk_intra = 1'b0;
        pred_valid = 1'b1; pred_data = 16'h0; rec_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_mc", int'(ready_mc), 1);
        check("rst_pixel_addr", int'(pixel_addr), 0);
        check("rst_pixel_coded", int'(pixel_coded), 0);
        check("rst_pred_ready", int'(pred_ready), 0);
        check("rst_rec_valid", int'(rec_valid), 0);
        check("rst_rec_last", int'(rec_last), 0);
        check("rst_blk_done", int'(blk_done), 0);
        check("rst_rec_data", int'(rec_data), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        run_block(1'b0, 1'b0, 0, 0, 1);   // uncoded inter, pred passes through
        run_block(1'b1, 1'b0, 0, 0, 2);   // coded add and clip vectors
        run_block(1'b1, 1'b1, 2, 0, 3);   // intra, no prediction stream
        run_block(1'b1, 1'b0, 1, 1, 0);   // backpressure with random pred_valid

        run_block(1'b1, 1'b0, 0, 0, 0);   // full-rate throughput
        check("tp_issue_span", last_issue - first_issue, 31);
        check("tp_latency", first_valid - first_issue, 2);
        check("tp_valid_span", last_valid - first_valid, 31);
        check("tp_valid_count", n_valid, 32);

        for (int b = 0; b < 4; b++) begin
            c  = 1'($urandom_range(0, 1));
            in = 1'($urandom_range(0, 1));
            run_block(c, in, 1, 2, 0);
        end

        // softreset mid-block, with blk_start pulses that must be ignored
        prep_block(1'b1, 1'b0, 0);
        start_block(1'b1, 1'b0, 0, 0);
        a0 = acc_cnt;
        for (int i = 0; i < 100 && acc_cnt - a0 < 10; i++) cycle();
        check("pairs_before_softreset", int'(acc_cnt - a0 >= 10), 1);
        blk_start = 1'b1;
        blk_coded = 1'b0;
        blk_intra = 1'b1;
        cycle();
        check("coded_after_ignored_start", int'(pixel_coded), 1);
        check("busy_after_ignored_start", int'(ready_mc), 0);
        softreset = 1'b1;
        blk_start = 1'b1;
        blk_coded = 1'b1;
        cycle();
        exp_q.delete();
        pidx = 0;
        check("sr_ready_mc", int'(ready_mc), 1);
        check("sr_rec_valid", int'(rec_valid), 0);
        check("sr_pixel_addr", int'(pixel_addr), 0);
        check("sr_pred_ready", int'(pred_ready), 0);
        check("sr_pixel_coded", int'(pixel_coded), 0);
        check("sr_rec_data", int'(rec_data), 0);
        run_block(1'b1, 1'b0, 1, 2, 0);   // restarts cleanly at pair 0

        repeat (3) cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
